// File: rtl/bsg_coatcheck_pkg.sv
// rtl/bsg_coatcheck_pkg.sv - shared width helpers for the coatcheck metadata front end
//
// Purpose: width helpers shared by the coatcheck top and its tests.
//   safe_clog2(n)    : ceil(log2(n)), never less than 1, so an ID field always exists.
//   count_width(els) : width of an occupancy counter that must reach els (0..els inclusive).
package bsg_coatcheck_pkg;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int count_width(input int els);
    return safe_clog2(els) + 1;
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// rtl/bsg_mem_1r1w.sv - one-write one-read register-file memory, asynchronous read
//
// Purpose: els_p x width_p storage with a clocked write port and a combinational read port.
//   Contents are never reset.
// Ports:
//   w_clk_i            write clock
//   w_v_i/w_addr_i/w_data_i   write enable, address, data
//   r_v_i/r_addr_i     read valid (only used by the collision check), read address
//   r_data_o           read data, combinational from r_addr_i
module bsg_mem_1r1w
  import bsg_coatcheck_pkg::*;
#(
  parameter int width_p                = 8,
  parameter int els_p                  = 4,
  parameter int read_write_same_addr_p = 0,
  localparam int addr_width_lp         = safe_clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge w_clk_i) begin
    if (w_v_i) begin
      mem_r[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_r[r_addr_i];

  // A read of the location being written would return stale data.
  assert property (@(posedge w_clk_i)
    (read_write_same_addr_p != 0) || !(w_v_i && r_v_i && (w_addr_i == r_addr_i)));

endmodule

// File: rtl/bsg_coatcheck_meta.sv
// rtl/bsg_coatcheck_meta.sv - coatcheck front end: tags requests with pool IDs, matches responses to metadata
//
// Purpose: issues each request with a free ID from an external pool, keeps its metadata in a
//   per-ID table, pairs out-of-order responses with that metadata through a one-entry output
//   register, and hands the ID back to the pool.
// Ports:
//   clk_i, reset_n_i                           clock, synchronous active-low reset
//   req_v_i/req_meta_i/req_data_i/req_yumi_o   incoming request
//   alloc_id_i/alloc_v_i/alloc_yumi_o          free-ID supply from the pool
//   dealloc_v_o/dealloc_id_o                   ID returned to the pool
//   tag_v_o/tag_id_o/tag_data_o/tag_ready_i    tagged request to the responder
//   rsp_v_i/rsp_id_i/rsp_data_i/rsp_ready_o    out-of-order response
//   out_v_o/out_meta_o/out_data_o/out_yumi_i   matched response to the consumer
//   outstanding_o, empty_o                     IDs currently held, and whether none are
//   err_o                                      sticky: response carried an ID that was not held
// Configuration: BSG_COATCHECK_META_CHECK_EN keeps a per-ID ownership vector and flags
//   responses with unowned IDs via err_o; without it err_o is 0 and responses are trusted.
module bsg_coatcheck_meta
  import bsg_coatcheck_pkg::*;
#(
  parameter int els_p        = 4,
  parameter int meta_width_p = 8,
  parameter int data_width_p = 16,
  localparam int id_width_lp = safe_clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    req_v_i,
  input  logic [meta_width_p-1:0] req_meta_i,
  input  logic [data_width_p-1:0] req_data_i,
  output logic                    req_yumi_o,
  input  logic [id_width_lp-1:0]  alloc_id_i,
  input  logic                    alloc_v_i,
  output logic                    alloc_yumi_o,
  output logic                    dealloc_v_o,
  output logic [id_width_lp-1:0]  dealloc_id_o,
  output logic                    tag_v_o,
  output logic [id_width_lp-1:0]  tag_id_o,
  output logic [data_width_p-1:0] tag_data_o,
  input  logic                    tag_ready_i,
  input  logic                    rsp_v_i,
  input  logic [id_width_lp-1:0]  rsp_id_i,
  input  logic [data_width_p-1:0] rsp_data_i,
  output logic                    rsp_ready_o,
  output logic                    out_v_o,
  output logic [meta_width_p-1:0] out_meta_o,
  output logic [data_width_p-1:0] out_data_o,
  input  logic                    out_yumi_i,
  output logic [id_width_lp:0]    outstanding_o,
  output logic                    empty_o,
  output logic                    err_o
);

  localparam int cnt_width_lp = count_width(els_p);

  typedef struct packed {
    logic [id_width_lp-1:0]  id;
    logic [data_width_p-1:0] data;
  } tag_req_s;

  typedef struct packed {
    logic [meta_width_p-1:0] meta;
    logic [data_width_p-1:0] data;
  } match_rsp_s;

  tag_req_s                tag_req;
  match_rsp_s              out_r;
  logic                    out_v_r;
  logic [cnt_width_lp-1:0] cnt_r;
  logic [meta_width_p-1:0] meta_rd;
  logic                    fire;
  logic                    rsp_acc;
  logic                    rsp_ok;

  // Issue path: purely combinational, valid never looks at ready.
  assign tag_req      = '{id: alloc_id_i, data: req_data_i};
  assign tag_v_o      = req_v_i & alloc_v_i;
  assign tag_id_o     = tag_req.id;
  assign tag_data_o   = tag_req.data;
  assign fire         = tag_v_o & tag_ready_i;
  assign req_yumi_o   = fire;
  assign alloc_yumi_o = fire;

  // One-entry output pipe: accept whenever the slot is empty or being drained this cycle.
  assign rsp_ready_o = ~out_v_r | out_yumi_i;
  assign rsp_acc     = rsp_v_i & rsp_ready_o;

`ifdef BSG_COATCHECK_META_CHECK_EN
  logic [els_p-1:0] owned_r;
  logic             err_r;
  logic             rsp_owned;

  assign rsp_owned = owned_r[rsp_id_i];
  // An unowned response is swallowed: accepted, but neither output nor returned to the pool.
  assign rsp_ok    = rsp_acc & rsp_owned;
  assign err_o     = err_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      owned_r <= '0;
      err_r   <= 1'b0;
    end else begin
      // Issue and response never name the same ID in one cycle, so both updates can land.
      if (fire) owned_r[alloc_id_i] <= 1'b1;
      if (rsp_ok) owned_r[rsp_id_i] <= 1'b0;
      if (rsp_acc & ~rsp_owned) err_r <= 1'b1;
    end
  end
`else
  assign rsp_ok = rsp_acc;
  assign err_o  = 1'b0;
`endif

  bsg_mem_1r1w #(
    .width_p               (meta_width_p),
    .els_p                 (els_p),
    .read_write_same_addr_p(0)
  ) meta_mem (
    .w_clk_i (clk_i),
    .w_v_i   (fire),
    .w_addr_i(alloc_id_i),
    .w_data_i(req_meta_i),
    .r_v_i   (rsp_acc),
    .r_addr_i(rsp_id_i),
    .r_data_o(meta_rd)
  );

  assign dealloc_v_o  = rsp_ok;
  assign dealloc_id_o = rsp_id_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      out_v_r <= 1'b0;
    end else if (rsp_ok) begin
      out_v_r <= 1'b1;
    end else if (out_yumi_i) begin
      out_v_r <= 1'b0;
    end
  end

  // Payload register is not reset; it is qualified by out_v_r.
  always_ff @(posedge clk_i) begin
    if (rsp_ok) begin
      out_r <= '{meta: meta_rd, data: rsp_data_i};
    end
  end

  assign out_v_o    = out_v_r;
  assign out_meta_o = out_r.meta;
  assign out_data_o = out_r.data;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_r <= '0;
    end else if (fire & ~rsp_ok) begin
      cnt_r <= cnt_r + cnt_width_lp'(1);
    end else if (rsp_ok & ~fire) begin
      cnt_r <= cnt_r - cnt_width_lp'(1);
    end
  end

  assign outstanding_o = cnt_r;
  assign empty_o       = (cnt_r == '0);

  assert property (@(posedge clk_i) disable iff (!reset_n_i) out_yumi_i |-> out_v_r);
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (rsp_ok & ~fire) |-> (cnt_r != '0));
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (fire & ~rsp_ok) |-> (cnt_r != cnt_width_lp'(els_p)));

endmodule
